// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu -- load/store unit for the RV32E core (data-memory initiator).
//
// Accepts one decoded load/store from EXU, checks funct3 legality and
// alignment, then issues a word-aligned request with a byte write mask over
// a valid/ready request channel and waits for the memory response. It returns
// sign/zero-extended load data, a store completion, or an error to WBU. At most
// one transaction is in flight.
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   in_valid/in_ready   EXU handshake (ready only in IDLE)
//   in_is_store         1 = store, 0 = load
//   in_funct3           RISC-V funct3 of the memory op
//   in_addr             effective byte address
//   in_wdata            right-aligned store data (rs2)
//   mem_req_valid/ready request handshake to memory
//   mem_wen             1 = write request
//   mem_addr            word-aligned address
//   mem_wdata           store data shifted into its byte lanes
//   mem_wmask           byte-lane write mask (bits [7:4] always 0)
//   mem_rsp_valid       one response per accepted request
//   mem_rdata           full aligned word for loads
//   out_valid/out_ready result handshake to WBU
//   out_rdata           extended load data (0 for stores and errors)
//   out_err             misaligned or illegal funct3; no memory access made
// ----------------------------------------------------------------------------
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        accept;
  logic        legal;
  logic        misaligned;
  logic        req_ok;
  logic [7:0]  wmask_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Handshake outputs are pure state decodes, so nothing from mem_* inputs
  // reaches mem_* outputs combinationally.
  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign out_valid     = (state_q == DONE);

  assign accept = in_ready && in_valid;

  // Decode of the incoming op (only meaningful while accepting).
  // NOTE: every signal driven in always_comb gets a default first so no
  // path through the case statements can leave it unassigned (latch).
  always_comb begin
    legal = 1'b0;
    if (in_is_store) begin
      legal = ~in_funct3[2] && (in_funct3[1:0] != 2'b11);
    end else begin
      unique case (in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (in_funct3[1:0])
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = |in_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign req_ok = legal && !misaligned;

  always_comb begin
    wmask_d = 8'h00;
    unique case (in_funct3[1:0])
      2'b00:   wmask_d = 8'h01 << in_addr[1:0];
      2'b01:   wmask_d = 8'h03 << in_addr[1:0];
      default: wmask_d = 8'h0F;
    endcase
  end

  assign wdata_d = in_wdata << {in_addr[1:0], 3'b000};

  // Load extraction from the latched offset/funct3; the response word is
  // consumed only in the WAIT->DONE transition.
  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = shifted;
    unique case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)      state_d = req_ok ? REQ : DONE;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid) state_d = DONE;
      DONE: if (out_ready)     state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      mem_wen    <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wmask  <= 8'h00;
      out_rdata  <= 32'h0;
      out_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= in_is_store;
        funct3_q   <= in_funct3;
        off_q      <= in_addr[1:0];
        out_rdata  <= 32'h0;
        out_err    <= !req_ok;
        // The request payload is formed once at accept so it stays stable
        // for the whole REQ stall.
        if (req_ok) begin
          mem_wen   <= in_is_store;
          mem_addr  <= {in_addr[31:2], 2'b00};
          mem_wdata <= in_is_store ? wdata_d : 32'h0;
          mem_wmask <= in_is_store ? wmask_d : 8'h00;
        end
      end
      if ((state_q == WAIT) && mem_rsp_valid) begin
        out_rdata <= is_store_q ? 32'h0 : load_data;
      end
    end
  end

endmodule
